// File: rtl/sdram_arbiter.sv
// Two-port SDRAM command arbiter with a read-tag FIFO that routes returning read data.
// Define SDRAM_ARB_RR_EN for round-robin grant; the default build uses fixed priority (port 0 first).
module sdram_arbiter #(
    parameter int DW    = 16,
    parameter int AW    = 23,
    parameter int MAXRD = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [AW-1:0]     p0_addr,
    input  logic [DW-1:0]     p0_wdata,
    input  logic [DW/8-1:0]   p0_byteenable,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DW-1:0]     p0_rdata,

    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [AW-1:0]     p1_addr,
    input  logic [DW-1:0]     p1_wdata,
    input  logic [DW/8-1:0]   p1_byteenable,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DW-1:0]     p1_rdata,

    output logic              sdram_req,
    output logic              sdram_write,
    output logic [AW-1:0]     sdram_addr,
    output logic [DW-1:0]     sdram_wdata,
    output logic [DW/8-1:0]   sdram_byteenable,
    input  logic              sdram_ready,
    input  logic              sdram_rvalid,
    input  logic [DW-1:0]     sdram_rdata,

    output logic              err_orphan
);

    localparam int PW = (MAXRD > 1) ? $clog2(MAXRD) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAXRD_C = CW'(MAXRD);
    localparam logic [CW-1:0] ZERO_C  = '0;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          tag_q [MAXRD];
    logic          last_grant_q, last_grant_d;
    logic          hold_q, hold_d;
    logic          hold_id_q, hold_id_d;
    logic          err_orphan_q, err_orphan_d;

    logic grant_s;
    logic any_req_s;
    logic tag_full_s;
    logic accept_s;
    logic push_s;
    logic pop_s;
    logic orphan_s;
    logic head_s;

    assign any_req_s  = p0_req | p1_req;
    assign tag_full_s = (count_q == MAXRD_C);
    assign head_s     = tag_q[rd_ptr_q];

    // Grant: a port left waiting on sdram_ready keeps the grant until it is accepted.
    always_comb begin
        grant_s = 1'b0;
        if (hold_q && (hold_id_q ? p1_req : p0_req)) begin
            grant_s = hold_id_q;
        end else begin
`ifdef SDRAM_ARB_RR_EN
            if (p0_req && p1_req) begin
                grant_s = ~last_grant_q;
            end else begin
                grant_s = ~p0_req & p1_req;
            end
`else
            grant_s = ~p0_req & p1_req;
`endif
        end
    end

    // Command path muxes straight from the granted port.
    always_comb begin
        sdram_req        = any_req_s & ~tag_full_s & ~rst;
        p0_ready         = ~grant_s & p0_req & sdram_ready & ~tag_full_s & ~rst;
        p1_ready         =  grant_s & p1_req & sdram_ready & ~tag_full_s & ~rst;
        if (grant_s) begin
            sdram_write      = p1_write;
            sdram_addr       = p1_addr;
            sdram_wdata      = p1_wdata;
            sdram_byteenable = p1_byteenable;
        end else begin
            sdram_write      = p0_write;
            sdram_addr       = p0_addr;
            sdram_wdata      = p0_wdata;
            sdram_byteenable = p0_byteenable;
        end
    end

    assign accept_s = sdram_req & sdram_ready;
    assign push_s   = accept_s & ~sdram_write;
    assign pop_s    = sdram_rvalid & (count_q != ZERO_C) & ~rst;
    assign orphan_s = sdram_rvalid & (count_q == ZERO_C);

    // Read return routing: head tag selects the port; rdata is shared.
    always_comb begin
        p0_rvalid = pop_s & ~head_s;
        p1_rvalid = pop_s &  head_s;
        p0_rdata  = sdram_rdata;
        p1_rdata  = sdram_rdata;
    end

    assign err_orphan = err_orphan_q;

    // Next-state for tag FIFO bookkeeping, grant history and error flag.
    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_grant_d = last_grant_q;
        err_orphan_d = err_orphan_q | orphan_s;
        hold_d       = sdram_req & ~sdram_ready;
        hold_id_d    = grant_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        if (accept_s) begin
            last_grant_d = grant_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_grant_q <= 1'b1;
            hold_q       <= 1'b0;
            hold_id_q    <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            hold_id_q    <= hold_id_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage holds the requester ID of each outstanding read.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            tag_q[wr_ptr_q] <= grant_s;
        end
    end

endmodule
